// File: rtl/mult_div_if.sv
// ---------------------------------------------------------------------------
// mult_div_if: request/result bundle for mult_div_unit.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mult_div_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, src_a, src_b,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU, one bit per cycle.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_div_unit (
   input  logic       clk,
   input  logic       rst,
   mult_div_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [5:0] C_LAST_ITER = 6'd32;

   state_t      r_state;
   state_t      w_next;
   logic [5:0]  r_cnt;
   logic        r_is_div;
   logic        r_neg_lo;
   logic        r_neg_hi;
   logic        r_dbz;
   logic [31:0] r_mag_a;
   logic [31:0] r_mag_b;
   logic [31:0] r_raw_a;
   logic [63:0] r_acc;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_done;
   logic        r_div_by_zero;

   logic        w_accept;
   logic        w_sign_a;
   logic        w_sign_b;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_mul_sum;
   logic [32:0] w_rem_sh;
   logic        w_rem_ge;
   logic [31:0] w_rem_new;
   logic [63:0] w_iter;
   logic [63:0] w_neg_acc;
   logic [31:0] w_neg_q;
   logic [31:0] w_neg_r;

   // Start is only honoured when not busy (IDLE or FIN).
   assign w_accept  = (r_state != CALC) && bus.start;
   assign w_sign_a  = ~bus.op[0] & bus.src_a[31];
   assign w_sign_b  = ~bus.op[0] & bus.src_b[31];
   assign w_abs_a   = w_sign_a ? (32'd0 - bus.src_a) : bus.src_a;
   assign w_abs_b   = w_sign_b ? (32'd0 - bus.src_b) : bus.src_b;

   // Multiply: accumulator upper half gathers partial sums, multiplier shifts out of the low half.
   assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_a} : 33'd0);
   // Divide: upper half is the partial remainder, low half shifts dividend out and quotient in.
   assign w_rem_sh  = r_acc[63:31];
   assign w_rem_ge  = w_rem_sh >= {1'b0, r_mag_b};
   assign w_rem_new = 32'(w_rem_sh - {1'b0, r_mag_b});

   always_comb begin
      w_iter = {w_mul_sum, r_acc[31:1]};
      if (r_is_div) begin
         if (w_rem_ge)
            w_iter = {w_rem_new, r_acc[30:0], 1'b1};
         else
            w_iter = {r_acc[62:0], 1'b0};
      end
   end

   assign w_neg_acc = 64'd0 - r_acc;
   assign w_neg_q   = 32'd0 - r_acc[31:0];
   assign w_neg_r   = 32'd0 - r_acc[63:32];

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = CALC;
         CALC:    if (r_dbz || (r_cnt == C_LAST_ITER)) w_next = FIN;
         FIN:     w_next = bus.start ? CALC : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt         <= 6'd0;
         r_is_div      <= 1'b0;
         r_neg_lo      <= 1'b0;
         r_neg_hi      <= 1'b0;
         r_dbz         <= 1'b0;
         r_mag_a       <= 32'd0;
         r_mag_b       <= 32'd0;
         r_raw_a       <= 32'd0;
         r_acc         <= 64'd0;
         r_hi          <= 32'd0;
         r_lo          <= 32'd0;
         r_done        <= 1'b0;
         r_div_by_zero <= 1'b0;
      end else begin
         r_done        <= 1'b0;
         r_div_by_zero <= 1'b0;
         if (w_accept) begin
            r_is_div <= bus.op[1];
            r_mag_a  <= w_abs_a;
            r_mag_b  <= w_abs_b;
            r_raw_a  <= bus.src_a;
            r_neg_lo <= w_sign_a ^ w_sign_b;
            r_neg_hi <= w_sign_a;
            r_dbz    <= bus.op[1] && (bus.src_b == 32'd0);
            r_cnt    <= 6'd0;
            r_acc    <= {32'd0, bus.op[1] ? w_abs_a : w_abs_b};
         end else if (r_state == CALC) begin
            if (r_dbz) begin
               r_hi          <= r_raw_a;
               r_lo          <= 32'hFFFF_FFFF;
               r_done        <= 1'b1;
               r_div_by_zero <= 1'b1;
            end else if (r_cnt == C_LAST_ITER) begin
               r_done <= 1'b1;
               if (r_is_div) begin
                  r_lo <= r_neg_lo ? w_neg_q : r_acc[31:0];
                  r_hi <= r_neg_hi ? w_neg_r : r_acc[63:32];
               end else begin
                  {r_hi, r_lo} <= r_neg_lo ? w_neg_acc : r_acc;
               end
            end else begin
               r_acc <= w_iter;
               r_cnt <= r_cnt + 6'd1;
            end
         end
      end
   end

   assign bus.busy        = (r_state == CALC);
   assign bus.done        = r_done;
   assign bus.div_by_zero = r_div_by_zero;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port RST, input, 1 bit: reset; synchronous, active-high.
REQ-003 The block SHALL have the port Start, input, 1 bit: request a new operation; sampled only while Busy=0.
REQ-004 The block SHALL have the port Op, input, 2 bits: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 The block SHALL have the port SrcA, input, 32 bits: multiplicand or dividend; driven from register-file ReadData1 (rs).
REQ-006 The block SHALL have the port SrcB, input, 32 bits: multiplier or divisor; driven from register-file ReadData2 (rt).
REQ-007 The block SHALL have the port Busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have the port Done, output, 1 bit: one-cycle pulse when HI/LO hold a new result.
REQ-009 The block SHALL have the port DivByZero, output, 1 bit: high with Done when the completed DIV or DIVU had SrcB=0.
REQ-010 The block SHALL have the port HI, output, 32 bits: product upper word or remainder.
REQ-011 The block SHALL have the port LO, output, 32 bits: product lower word or quotient.

Function
REQ-012 The block SHALL implement three states: IDLE, CALC and FIN.
REQ-013 The block SHALL accept Start=1 with Busy=0 (IDLE or FIN) at a rising edge, called edge 0. At edge 0 it SHALL latch Op, the operand magnitudes and the result signs, clear the iteration counter and enter CALC.
REQ-014 The block SHALL ignore Start while Busy=1, with no effect on state, operands or outputs.
REQ-015 The block SHALL hold Busy=1 in CALC only, and Busy=0 in IDLE and FIN.
REQ-016 In CALC the block SHALL perform exactly one iteration per cycle, 32 iterations in total on edges 1..32. A multiply iteration is a radix-2 shift-add into a 64-bit accumulator. A divide iteration is a restoring shift-subtract.
REQ-017 At edge 33 the block SHALL write the sign-corrected result to HI/LO, enter FIN and assert Done=1 for that one cycle.
REQ-018 The block SHALL leave FIN for IDLE on the next edge unless Start=1, in which case it SHALL accept the new operation (back-to-back issue).
REQ-019 For MULT, {HI,LO} SHALL be the 64-bit two's-complement signed product. For MULTU, {HI,LO} SHALL be the unsigned product.
REQ-020 For DIV, LO SHALL be the quotient truncated toward zero and HI SHALL be the remainder carrying the sign of the dividend. For DIVU, LO and HI SHALL be the unsigned quotient and remainder.
REQ-021 For DIV 0x80000000 / 0xFFFFFFFF, the block SHALL give LO=0x80000000, HI=0x00000000 and DivByZero=0.
REQ-022 For DIV or DIVU with SrcB=0, the block SHALL skip CALC and enter FIN at edge 1. It SHALL then set LO=0xFFFFFFFF and HI=SrcA as latched, and assert Done=1 and DivByZero=1 together.
REQ-023 The block SHALL hold HI and LO stable outside the completion edge, so that the last result stays readable indefinitely.
REQ-024 DivByZero SHALL be valid only while Done=1, and SHALL read 0 otherwise.
REQ-025 The block SHALL use the operands latched at edge 0; changes on SrcA and SrcB after edge 0 SHALL have no effect.

Reset
REQ-026 RST=1 at a rising edge SHALL force state to IDLE, and HI, LO, Busy, Done and DivByZero to 0. It SHALL also clear the counter and internal registers.
REQ-027 RST SHALL take priority over Start and over any in-progress operation. An operation aborted mid-CALC SHALL produce no Done and no HI/LO update.
REQ-028 In the first cycle after RST deasserts, the block SHALL accept Start.

Verification
REQ-029 The bench SHALL cover MULT SrcA=0xFFFFFFFD (-3), SrcB=0x00000007 -> Done at edge 33 with HI=0xFFFFFFFF, LO=0xFFFFFFEB, Busy high on edges 1..32.
REQ-030 The bench SHALL cover MULTU SrcA=SrcB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 The bench SHALL cover DIV SrcA=0xFFFFFFF9 (-7), SrcB=0x00000002 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). It SHALL also cover DIVU 100/7 -> LO=14, HI=2.
REQ-032 The bench SHALL cover DIVU SrcA=0x12345678, SrcB=0 -> Done and DivByZero at edge 1, LO=0xFFFFFFFF, HI=0x12345678.
REQ-033 The bench SHALL cover Start during CALC, SrcA and SrcB changed mid-operation, then Start held high in FIN -> first result unaffected and second operation accepted at the FIN edge.
REQ-034 The bench SHALL cover RST=1 at edge 10 of a MULT -> all outputs 0, no Done pulse, and a Start at the next edge completes normally 33 edges later.
